// File: rtl/adder_share_if.sv
// adder_share_if
//   Bundles the signals between the round-robin adder scheduler, its
//   requesters, its response consumer and the shared combinational adder.
//
//   req_valid [N_REQ]        requester i has an operand pair
//   req_ready [N_REQ]        requester i's pair is taken this cycle (one-hot or zero)
//   req_a/req_b [N_REQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   adder_a/adder_b [WIDTH]  registered operands to the shared adder
//   adder_c [WIDTH]          sum returned by the shared adder
//   rsp_valid/rsp_ready      response handshake
//   rsp_data [WIDTH]         registered sum
//   rsp_id [ID_W]            requester that owns rsp_data
//
//   master: the scheduler side.  slave: requesters, consumer and adder.
interface adder_share_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]       adder_a;
  logic [WIDTH-1:0]       adder_b;
  logic [WIDTH-1:0]       adder_c;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    input  req_valid, req_a, req_b, adder_c, rsp_ready,
    output req_ready, adder_a, adder_b, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    output req_valid, req_a, req_b, adder_c, rsp_ready,
    input  req_ready, adder_a, adder_b, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Round-robin scheduler that time-shares one combinational adder among
//   N_REQ requesters. One operation is in flight at a time:
//   IDLE (grant + capture) -> CALC (adder settles) -> RESP (hold until taken).
//
//   clk  rising-edge clock
//   rst  synchronous active-high reset; drops any in-flight operation
//   bus  adder_share_if.master: request handshakes, shared adder A/B/C,
//        response channel (see the interface file for the signal list)
module adder_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  adder_share_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [ID_W-1:0]  id_p0;
  logic [WIDTH-1:0] rsp_data_p1;
  logic [ID_W-1:0]  rsp_id_p1;
  logic             vld_p1;

  // Successor of a requester id, wrapping N_REQ-1 back to 0 (N_REQ need
  // not be a power of two).
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Round-robin winner: first valid requester scanning from rr_ptr upward.
  // The loop runs downward so the closest candidate is assigned last.
  always_comb begin
    logic [ID_W:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(N_REQ)) begin
        idx = idx - (ID_W + 1)'(N_REQ);
      end
      if (bus.req_valid[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are only offered from IDLE and never while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if ((state == IDLE) && !rst && grant_vld) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      id_p0       <= '0;
      op_a_p0     <= '0;
      op_b_p0     <= '0;
      rsp_data_p1 <= '0;
      rsp_id_p1   <= '0;
      vld_p1      <= 1'b0;
    end else begin
      case (state)
        // Stage p0: capture the winner's operands; they stay on the adder
        // inputs until the next grant.
        IDLE: begin
          if (grant_vld) begin
            op_a_p0 <= sel_a;
            op_b_p0 <= sel_b;
            id_p0   <= grant_id;
          end
        end
        // Stage p1: register the adder output; the carry-out is not
        // available from the shared adder, so the sum wraps.
        CALC: begin
          rsp_data_p1 <= bus.adder_c;
          rsp_id_p1   <= id_p0;
          vld_p1      <= 1'b1;
        end
        // Last-served requester drops to lowest priority.
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            rr_ptr <= next_id(id_p0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.adder_a   = op_a_p0;
  assign bus.adder_b   = op_b_p0;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_id    = rsp_id_p1;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl
//   Directed bench for adder_share_ctrl. A transaction-level model (round-robin
//   pick over the valid vector, a busy flag and a cycles-since-grant count)
//   predicts req_ready, adder inputs and the response every cycle; directed
//   scenarios add hand-computed expectations on the grant/response logs.
module tb_adder_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  // The shared adder lives outside the controller.
  assign bus.adder_c = bus.adder_a + bus.adder_b;

  adder_share_ctrl #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int data;
    int cyc;
  } ev_t;
  ev_t grant_log[$];
  ev_t rsp_log[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Model state: one operation outstanding at most.
  bit m_ok   = 1'b0;
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_ptr  = 0;
  int m_a    = 0;
  int m_b    = 0;
  int m_id   = 0;
  int m_sum  = 0;

  always @(negedge clk) begin
    int w;
    int er;
    w  = (!rst && !m_busy) ? rr_pick(bus.req_valid, m_ptr) : -1;
    er = (w >= 0) ? (1 << w) : 0;
    chk("req_ready", int'(bus.req_ready), er);
    if (m_ok) begin
      chk("adder_a", int'(bus.adder_a), m_a);
      chk("adder_b", int'(bus.adder_b), m_b);
      chk("rsp_valid", int'(bus.rsp_valid), (m_busy && m_age >= 2) ? 1 : 0);
      if (m_busy && m_age >= 2) begin
        chk("rsp_data", int'(bus.rsp_data), m_sum);
        chk("rsp_id", int'(bus.rsp_id), m_id);
      end
    end
    if (rst) begin
      m_ok   = 1'b1;
      m_busy = 1'b0;
      m_age  = 0;
      m_ptr  = 0;
      m_a    = 0;
      m_b    = 0;
    end else if (m_ok) begin
      if (w >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = w;
        m_a    = int'(bus.req_a[w*W +: W]);
        m_b    = int'(bus.req_b[w*W +: W]);
        m_sum  = (m_a + m_b) % 256;
        grant_log.push_back('{w, m_sum, cyc});
      end else if (m_busy) begin
        if (m_age >= 2 && bus.rsp_ready) begin
          rsp_log.push_back('{m_id, m_sum, cyc});
          m_busy = 1'b0;
          m_ptr  = (m_id + 1) % N;
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic set_req(int i, bit v, int a, int b);
    bus.req_valid[i]     = v;
    bus.req_a[i*W +: W]  = W'(a);
    bus.req_b[i*W +: W]  = W'(b);
  endtask

  task automatic wait_grant(int target, string name);
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= target) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_rsp(int target, string name);
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (rsp_log.size() >= target) return;
    end
    timeout_fail(name);
  endtask

  task automatic serve(int id, int a, int b, string name);
    int g;
    g = grant_log.size();
    set_req(id, 1'b1, a, b);
    wait_grant(g + 1, name);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic chk_rsp(int idx, int id, int data, string name);
    if (rsp_log.size() > idx) begin
      chk({name, "_id"}, rsp_log[idx].id, id);
      chk({name, "_data"}, rsp_log[idx].data, data);
    end else begin
      timeout_fail(name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_adder_a", int'(bus.adder_a), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_data", int'(bus.rsp_data), 0);
    rst = 1'b0;

    // Single request: 2 + 2 from requester 0.
    bus.rsp_ready = 1'b1;
    serve(0, 2, 2, "t1_grant");
    wait_rsp(1, "t1_rsp");
    @(posedge clk);
    #1;
    chk("t1_grant_count", grant_log.size(), 1);
    chk_rsp(0, 0, 8'h04, "t1");
    if (rsp_log.size() > 0 && grant_log.size() > 0)
      chk("t1_latency", rsp_log[0].cyc - grant_log[0].cyc, 2);

    // Wrapping sums from requester 3.
    serve(3, 8'h92, 8'hAB, "t2a_grant");
    wait_rsp(2, "t2a_rsp");
    chk_rsp(1, 3, 8'h3D, "t2a");
    serve(3, 8'hFF, 8'h01, "t2b_grant");
    wait_rsp(3, "t2b_rsp");
    chk_rsp(2, 3, 8'h00, "t2b");

    // All four continuously valid with (i+1, 1).
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 1);
    wait_rsp(8, "t3_rsp");
    bus.req_valid = '0;
    chk_rsp(3, 0, 2, "t3_0");
    chk_rsp(4, 1, 3, "t3_1");
    chk_rsp(5, 2, 4, "t3_2");
    chk_rsp(6, 3, 5, "t3_3");
    chk_rsp(7, 0, 2, "t3_4");
    for (int k = 4; k < 8; k++)
      if (rsp_log.size() > k) chk("t3_spacing", rsp_log[k].cyc - rsp_log[k-1].cyc, 3);

    // Serve requester 3 so the pointer sits at 0, then 0 and 2 alternate.
    serve(3, 5, 6, "t4_pre_grant");
    wait_rsp(9, "t4_pre_rsp");
    chk_rsp(8, 3, 11, "t4_pre");
    g = grant_log.size();
    set_req(0, 1'b1, 8'h10, 8'h01);
    set_req(2, 1'b1, 8'h20, 8'h02);
    wait_grant(g + 4, "t4_grants");
    bus.req_valid = '0;
    wait_rsp(13, "t4_rsp");
    if (grant_log.size() >= g + 4) begin
      chk("t4_grant0", grant_log[g].id, 0);
      chk("t4_grant1", grant_log[g+1].id, 2);
      chk("t4_grant2", grant_log[g+2].id, 0);
      chk("t4_grant3", grant_log[g+3].id, 2);
    end
    chk_rsp(12, 2, 8'h22, "t4_last");

    // Backpressure: hold the response of requester 1 for 5 cycles.
    bus.rsp_ready = 1'b0;
    serve(1, 8'h10, 8'h20, "t5_grant");
    set_req(0, 1'b1, 8'h01, 8'h02);
    set_req(3, 1'b1, 8'h03, 8'h04);
    for (int t = 0; t < 10 && !bus.rsp_valid; t++) begin
      @(posedge clk);
      #1;
    end
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      #1;
      chk("t5_rsp_valid", int'(bus.rsp_valid), 1);
      chk("t5_rsp_data", int'(bus.rsp_data), 8'h30);
      chk("t5_rsp_id", int'(bus.rsp_id), 1);
      chk("t5_adder_a", int'(bus.adder_a), 8'h10);
      chk("t5_adder_b", int'(bus.adder_b), 8'h20);
      chk("t5_req_ready", int'(bus.req_ready), 0);
    end
    n = rsp_log.size();
    g = grant_log.size();
    bus.rsp_ready = 1'b1;
    wait_grant(g + 1, "t5_next_grant");
    bus.req_valid = '0;
    if (grant_log.size() > g && rsp_log.size() > n) begin
      chk("t5_next_id", grant_log[g].id, 3);
      chk("t5_next_gap", grant_log[g].cyc - rsp_log[n].cyc, 1);
    end
    chk_rsp(n, 1, 8'h30, "t5_held");
    wait_rsp(n + 2, "t5_next_rsp");
    chk_rsp(n + 1, 3, 8'h07, "t5_next");

    // Reset during CALC after moving the pointer to 2.
    serve(1, 1, 1, "t6_pre_grant");
    wait_rsp(n + 3, "t6_pre_rsp");
    chk_rsp(n + 2, 1, 2, "t6_pre");
    serve(2, 7, 8, "t6_grant");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rsp_valid", int'(bus.rsp_valid), 0);
    chk("t6_adder_a", int'(bus.adder_a), 0);
    chk("t6_adder_b", int'(bus.adder_b), 0);
    n = rsp_log.size();
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_stale_rsp", rsp_log.size(), n);
    g = grant_log.size();
    set_req(1, 1'b1, 8'h40, 8'h02);
    set_req(3, 1'b1, 8'h50, 8'h03);
    wait_grant(g + 1, "t6_after_grant");
    bus.req_valid = '0;
    if (grant_log.size() > g) chk("t6_after_id", grant_log[g].id, 1);
    wait_rsp(n + 1, "t6_after_rsp");
    chk_rsp(n, 1, 8'h42, "t6_after");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
